// File: rtl/trig_source_scan_ctrl.sv
// -----------------------------------------------------------------------------
// trig_source_scan_ctrl
//
// Purpose:
//   Scan sequencer for the trigger-coincidence mux. On Start it walks the mux
//   select (TrigCoincid) through every source enabled in ChannelMask, lowest
//   index first. For each source it lets the mux settle, counts rising edges
//   of the muxed trigger over a programmable window, and hands a
//   {source, count} record to the consumer over a valid/ready handshake.
//
// Ports:
//   Clk           in   1         system clock, rising edge
//   reset_n       in   1         synchronous reset, active low
//   Start         in   1         scan request, only looked at while idle
//   ChannelMask   in   4         sources to scan, captured on accepted Start
//   WindowLength  in   WINDOW_W  count window in cycles (0 behaves as 1)
//   TrigIn        in   1         muxed trigger, asynchronous to Clk
//   TrigCoincid   out  2         mux select
//   CountData     out  COUNT_W   saturating rising-edge count of the window
//   CountSource   out  2         source the count belongs to
//   CountValid    out  1         record valid, held until CountReady
//   CountReady    in   1         consumer accepts the record
//   Busy          out  1         scan in progress
//   Done          out  1         one-cycle pulse at scan completion
// -----------------------------------------------------------------------------
module trig_source_scan_ctrl #(
  parameter int WINDOW_W      = 16,
  parameter int COUNT_W       = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                Clk,
  input  logic                reset_n,
  input  logic                Start,
  input  logic [3:0]          ChannelMask,
  input  logic [WINDOW_W-1:0] WindowLength,
  input  logic                TrigIn,
  output logic [1:0]          TrigCoincid,
  output logic [COUNT_W-1:0]  CountData,
  output logic [1:0]          CountSource,
  output logic                CountValid,
  input  logic                CountReady,
  output logic                Busy,
  output logic                Done
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_COUNT,
    ST_OUTPUT,
    ST_DONE
  } state_t;

  state_t state, state_next;

  logic [3:0]          mask_q;
  logic [3:0]          mask_clr;
  logic [WINDOW_W-1:0] window_q;
  logic [WINDOW_W-1:0] win_cnt;
  logic [WINDOW_W-1:0] win_last_idx;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [COUNT_W-1:0]  edge_cnt;
  logic [COUNT_W-1:0]  count_next;
  logic [1:0]          next_idx;
  logic                settle_done;
  logic                window_last;
  logic                trig_s1, trig_s2, trig_prev;
  logic                trig_rise;

  // Two-flop synchroniser plus a history flop. The history flop runs in every
  // state so a level that is already high when counting begins never looks
  // like a fresh edge.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      trig_prev <= 1'b0;
    end else begin
      trig_s1   <= TrigIn;
      trig_s2   <= trig_s1;
      trig_prev <= trig_s2;
    end
  end

  assign trig_rise = trig_s2 & ~trig_prev;

  // Lowest remaining source. Serviced bits are cleared from mask_q, so the
  // lowest set bit is always the next source in ascending order.
  always_comb begin
    next_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i]) next_idx = 2'(i);
    end
  end

  // Mask as it will look once the current source's record is accepted.
  always_comb begin
    mask_clr              = mask_q;
    mask_clr[TrigCoincid] = 1'b0;
  end

  // A zero window is treated as one cycle so a scan always makes progress.
  assign win_last_idx = (window_q == '0) ? '0 : window_q - 1'b1;
  assign window_last  = (win_cnt == win_last_idx);
  assign settle_done  = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));

  // Saturating increment; the result feeds CountData directly so an edge in
  // the final window cycle is included in the record.
  assign count_next = (trig_rise && !(&edge_cnt)) ? edge_cnt + 1'b1 : edge_cnt;

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Start is only honoured in idle, so a request that
  // lands while busy (including the Done cycle) is simply dropped.
  always_comb begin
    state_next = state;
    Done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          state_next = (ChannelMask == 4'd0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_SELECT: begin
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_done) state_next = ST_COUNT;
      end
      ST_COUNT: begin
        if (window_last) state_next = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (CountReady) begin
          state_next = (mask_clr != 4'd0) ? ST_SELECT : ST_DONE;
        end
      end
      ST_DONE: begin
        Done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath. Mask and window are snapshotted at Start so the scan in flight
  // is immune to later changes on the inputs. The select only moves in
  // SELECT and otherwise holds, including after the scan finishes.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      mask_q      <= 4'd0;
      window_q    <= '0;
      win_cnt     <= '0;
      settle_cnt  <= '0;
      edge_cnt    <= '0;
      TrigCoincid <= 2'd0;
      CountData   <= '0;
      CountSource <= 2'd0;
      CountValid  <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            mask_q   <= ChannelMask;
            window_q <= WindowLength;
            Busy     <= 1'b1;
          end
        end
        ST_SELECT: begin
          TrigCoincid <= next_idx;
          settle_cnt  <= '0;
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          edge_cnt   <= '0;
          win_cnt    <= '0;
        end
        ST_COUNT: begin
          edge_cnt <= count_next;
          win_cnt  <= win_cnt + 1'b1;
          if (window_last) begin
            CountData   <= count_next;
            CountSource <= TrigCoincid;
            CountValid  <= 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (CountReady) begin
            CountValid <= 1'b0;
            mask_q     <= mask_clr;
          end
        end
        ST_DONE: begin
          Busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
